// File: rtl/shared_adder_sched.sv
// Round-robin scheduler sharing one WIDTH_OUT-bit adder between two requesters.
// Define SHARED_ADD_SAT_EN to make every addition saturate instead of wrapping.
module shared_adder_sched #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH_IN-1:0]  a0,
  input  logic [WIDTH_IN-1:0]  b0,
  input  logic [WIDTH_IN-1:0]  c0,
  input  logic [WIDTH_IN-1:0]  d0,
  input  logic                 sel0,
  input  logic [WIDTH_IN-1:0]  a1,
  input  logic [WIDTH_IN-1:0]  b1,
  input  logic [WIDTH_IN-1:0]  c1,
  input  logic [WIDTH_IN-1:0]  d1,
  input  logic                 sel1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 busy,
  output logic                 out_valid,
  output logic                 out_id,
  output logic [WIDTH_OUT-1:0] data_out1,
  output logic [WIDTH_OUT-1:0] data_out2
);

  typedef enum logic [1:0] {IDLE, ADD_AB, ADD_C, ADD_D} state_t;

  state_t                state_reg, state_next;
  logic [WIDTH_IN-1:0]   a_reg, b_reg, c_reg, d_reg;
  logic                  sel_reg;
  logic                  id_reg;
  logic                  rr_last_reg;
  logic [WIDTH_OUT-1:0]  ab_reg, abc_reg;
  logic                  out_valid_reg;
  logic                  out_id_reg;
  logic [WIDTH_OUT-1:0]  data1_reg, data2_reg;

  logic                  win0, win1, idle;
  logic [WIDTH_OUT-1:0]  add_a, add_b, add_sum;

  // On a tie the requester that was not served last wins.
  assign idle = (state_reg == IDLE);
  assign win0 = req0 && (!req1 || rr_last_reg);
  assign win1 = req1 && (!req0 || !rr_last_reg);
  assign gnt0 = !rst && idle && win0;
  assign gnt1 = !rst && idle && win1;
  assign busy = !idle;

  // Operand mux feeding the single shared adder.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_reg)
      ADD_AB: begin
        add_a = WIDTH_OUT'(a_reg);
        add_b = WIDTH_OUT'(b_reg);
      end
      ADD_C: begin
        add_a = ab_reg;
        add_b = WIDTH_OUT'(c_reg);
      end
      ADD_D: begin
        add_a = abc_reg;
        add_b = WIDTH_OUT'(d_reg);
      end
      default: ;
    endcase
  end

`ifdef SHARED_ADD_SAT_EN
  logic [WIDTH_OUT:0] sum_full;
  assign sum_full = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum  = sum_full[WIDTH_OUT] ? '1 : sum_full[WIDTH_OUT-1:0];
`else
  assign add_sum = add_a + add_b;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gnt0 || gnt1) state_next = ADD_AB;
      ADD_AB:  state_next = ADD_C;
      ADD_C:   state_next = sel_reg ? IDLE : ADD_D;
      ADD_D:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      d_reg         <= '0;
      sel_reg       <= 1'b0;
      id_reg        <= 1'b0;
      rr_last_reg   <= 1'b1;
      ab_reg        <= '0;
      abc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_id_reg    <= 1'b0;
      data1_reg     <= '0;
      data2_reg     <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (gnt0 || gnt1) begin
            a_reg       <= gnt1 ? a1 : a0;
            b_reg       <= gnt1 ? b1 : b0;
            c_reg       <= gnt1 ? c1 : c0;
            d_reg       <= gnt1 ? d1 : d0;
            sel_reg     <= gnt1 ? sel1 : sel0;
            id_reg      <= gnt1;
            rr_last_reg <= gnt1;
          end
        end
        ADD_AB: ab_reg <= add_sum;
        ADD_C: begin
          abc_reg <= add_sum;
          if (sel_reg) begin
            data1_reg     <= ab_reg;
            data2_reg     <= add_sum;
            out_valid_reg <= 1'b1;
            out_id_reg    <= id_reg;
          end
        end
        ADD_D: begin
          data1_reg     <= add_sum;
          data2_reg     <= abc_reg;
          out_valid_reg <= 1'b1;
          out_id_reg    <= id_reg;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_id    = out_id_reg;
  assign data_out1 = data1_reg;
  assign data_out2 = data2_reg;

endmodule

// File: tb/tb_shared_adder_sched.sv
// Directed bench for shared_adder_sched with hand-computed expected results.
module tb_shared_adder_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, c0 = '0, d0 = '0;
  logic [3:0] a1 = '0, b1 = '0, c1 = '0, d1 = '0;
  logic       sel0 = 1'b0, sel1 = 1'b0;
  logic       gnt0, gnt1, busy, out_valid, out_id;
  logic [4:0] data_out1, data_out2;

  int errors = 0;
  int checks = 0;

  shared_adder_sched #(.WIDTH_IN(4), .WIDTH_OUT(5)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .c0(c0), .d0(d0), .sel0(sel0),
    .a1(a1), .b1(b1), .c1(c1), .d1(d1), .sel1(sel1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .out_valid(out_valid), .out_id(out_id),
    .data_out1(data_out1), .data_out2(data_out2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Issue one isolated request and follow it through to its result strobe.
  task automatic run_req(input string nm, input logic id, input logic [3:0] a, b, c, d,
                         input logic sel, input int e1, input int e2);
    int n;
    step();
    if (id) begin
      a1 = a; b1 = b; c1 = c; d1 = d; sel1 = sel; req1 = 1'b1;
    end else begin
      a0 = a; b0 = b; c0 = c; d0 = d; sel0 = sel; req0 = 1'b1;
    end
    #1;
    check({nm, " gnt0"}, gnt0, (id == 1'b0) ? 1 : 0);
    check({nm, " gnt1"}, gnt1, (id == 1'b1) ? 1 : 0);
    step();
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; c0 = '0; d0 = '0; a1 = '0; b1 = '0; c1 = '0; d1 = '0;
    #1;
    check({nm, " busy after grant"}, busy, 1);
    check({nm, " gnt0 low when busy"}, gnt0, 0);
    n = sel ? 2 : 3;
    for (int i = 0; i < n; i++) begin
      step();
      if (i < n - 1) begin
        check({nm, " valid early"}, out_valid, 0);
        check({nm, " busy mid"}, busy, 1);
      end
    end
    check({nm, " valid"}, out_valid, 1);
    check({nm, " id"}, out_id, id);
    check({nm, " out1"}, data_out1, e1);
    check({nm, " out2"}, data_out2, e2);
    check({nm, " busy done"}, busy, 0);
    step();
    check({nm, " valid one cycle"}, out_valid, 0);
    check({nm, " out1 hold"}, data_out1, e1);
  endtask

  initial begin
    int pulses;
    int exp_id;
    #2;
    check("rst busy", busy, 0);
    check("rst valid", out_valid, 0);
    check("rst out1", data_out1, 0);
    check("rst out2", data_out2, 0);
    check("rst gnt0", gnt0, 0);
    do_reset();

    run_req("t1", 1'b0, 4'd3, 4'd4, 4'd5, 4'd6, 1'b0, 18, 12);
    run_req("t2", 1'b1, 4'd3, 4'd4, 4'd5, 4'd6, 1'b1, 7, 12);
`ifdef SHARED_ADD_SAT_EN
    run_req("t3", 1'b0, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 31, 31);
`else
    run_req("t3", 1'b0, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 28, 13);
`endif

    // Round robin with both requests held continuously.
    do_reset();
    a0 = 4'd1; b0 = 4'd2; c0 = 4'd3; d0 = 4'd4; sel0 = 1'b0;
    a1 = 4'd5; b1 = 4'd6; c1 = 4'd7; d1 = 4'd8; sel1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    #1;
    check("rr first gnt0", gnt0, 1);
    check("rr first gnt1", gnt1, 0);
    exp_id = 0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) step();
      check("rr valid", out_valid, 1);
      check("rr id", out_id, exp_id);
      check("rr out1", data_out1, (exp_id == 0) ? 10 : 26);
      check("rr out2", data_out2, (exp_id == 0) ? 6 : 18);
      exp_id = 1 - exp_id;
      check("rr gnt0", gnt0, (exp_id == 0) ? 1 : 0);
      check("rr gnt1", gnt1, (exp_id == 1) ? 1 : 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int j = 0; j < 5; j++) step();

    // Reset in ADD_C abandons the request; held req0 is re-granted after reset.
    req0 = 1'b1; sel0 = 1'b0;
    #1;
    check("mid gnt0", gnt0, 1);
    step();
    step();
    check("mid busy before rst", busy, 1);
    rst = 1'b1;
    #1;
    check("mid busy", busy, 0);
    check("mid out1", data_out1, 0);
    check("mid out2", data_out2, 0);
    check("mid gnt0 in rst", gnt0, 0);
    pulses = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      if (out_valid) pulses++;
    end
    rst = 1'b0;
    #1;
    check("mid regrant", gnt0, 1);
    step();
    req0 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (out_valid) pulses++;
      step();
    end
    check("mid pulses", pulses, 1);
    check("mid out1 after", data_out1, 10);

    // req0 raised and dropped while req1 is being served is ignored.
    step();
    a1 = 4'd1; b1 = 4'd1; c1 = 4'd1; d1 = 4'd1; sel1 = 1'b1; req1 = 1'b1;
    #1;
    check("drop gnt1", gnt1, 1);
    step();
    req1 = 1'b0; req0 = 1'b1;
    step();
    req0 = 1'b0;
    step();
    check("drop valid", out_valid, 1);
    check("drop id", out_id, 1);
    check("drop gnt0", gnt0, 0);
    pulses = 0;
    for (int j = 0; j < 3; j++) begin
      if (busy || gnt0 || gnt1) pulses++;
      step();
    end
    check("drop idle", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
